// File: rtl/ppu_types_pkg.sv
// ----------------------------------------------------------------------------
// ppu_types_pkg
// Shared PPU types and constants.
//   gb_color_t      2-bit colour ID as stored in the pixel FIFOs
//   ppu_mode_t      STAT mode encoding (HBLANK/VBLANK/OAM/DRAW)
//   FIFO_DEPTH      depth of the background pixel FIFO
//   SCREEN_WIDTH    visible pixels per line
//   SCREEN_HEIGHT   visible lines per frame
//   pusher_state_t  state encoding of the pixel pusher
// ----------------------------------------------------------------------------
package ppu_types_pkg;

    typedef logic [1:0] gb_color_t;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } ppu_mode_t;

    localparam int FIFO_DEPTH    = 16;
    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 144;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCARD,
        ST_PUSH,
        ST_DONE
    } pusher_state_t;

endpackage

// File: rtl/ppu_util_pkg.sv
// ----------------------------------------------------------------------------
// ppu_util_pkg
// Small helpers shared by the PPU datapaths.
//   apply_palette(pal, id)  maps a colour ID through a palette register
//                           (BGP, OBP0 or OBP1) and returns the 2-bit shade
// ----------------------------------------------------------------------------
package ppu_util_pkg;

    import ppu_types_pkg::*;

    function automatic logic [1:0] apply_palette(input logic [7:0] pal, input gb_color_t id);
        logic [1:0] shade;
        case (id)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            default: shade = pal[7:6];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/ppu_pixel_pusher.sv
// ----------------------------------------------------------------------------
// ppu_pixel_pusher
// Consumer end of the background pixel FIFO. During DRAW it pops one pixel
// per cycle, drops the first SCX[2:0] pixels of the line, maps the rest
// through BGP and writes the shade to the framebuffer at (LY, x).
//   clk, reset    system clock, synchronous active-high reset
//   mode          current PPU mode; a non-DRAW -> DRAW edge starts a line
//   ly            current line, latched at line start
//   scx_fine      SCX[2:0], number of pixels discarded at line start
//   bgp           BG palette, sampled per pixel
//   fifo_read_en  pop strobe (combinational)
//   fifo_head     oldest FIFO pixel, valid when fifo_empty = 0
//   fifo_empty    FIFO has no pixels
//   fb_we/fb_addr/fb_wdata  framebuffer write port, one cycle after the pop
//   x_pos         pixels written on the current line
//   line_done     one-cycle pulse with the write of pixel 159
// ----------------------------------------------------------------------------
module ppu_pixel_pusher #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 144,
    parameter int FB_ADDR_W     = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  ppu_types_pkg::ppu_mode_t mode,
    input  logic [7:0]               ly,
    input  logic [2:0]               scx_fine,
    input  logic [7:0]               bgp,
    output logic                     fifo_read_en,
    input  ppu_types_pkg::gb_color_t fifo_head,
    input  logic                     fifo_empty,
    output logic                     fb_we,
    output logic [FB_ADDR_W-1:0]     fb_addr,
    output logic [1:0]               fb_wdata,
    output logic [7:0]               x_pos,
    output logic                     line_done
);

    import ppu_types_pkg::*;
    import ppu_util_pkg::*;

    pusher_state_t          state_q, state_d;
    ppu_mode_t              prev_mode_q;
    logic [7:0]             ly_q, ly_d;
    logic [2:0]             discard_q, discard_d;
    logic [7:0]             x_pos_q, x_pos_d;
    logic                   fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [1:0]             fb_wdata_q, fb_wdata_d;
    logic                   line_done_q, line_done_d;
    logic                   read_en;
    logic                   in_draw;
    logic                   draw_edge;
    logic                   start_line;

    assign in_draw   = (mode == MODE_DRAW);
    assign draw_edge = in_draw && (prev_mode_q != MODE_DRAW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            // Reset as DRAW so a reset taken mid-line cannot look like a new line start.
            prev_mode_q <= MODE_DRAW;
            ly_q        <= '0;
            discard_q   <= '0;
            x_pos_q     <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_mode_q <= mode;
            ly_q        <= ly_d;
            discard_q   <= discard_d;
            x_pos_q     <= x_pos_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_wdata_q  <= fb_wdata_d;
            line_done_q <= line_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ly_d        = ly_q;
        discard_d   = discard_q;
        x_pos_d     = x_pos_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_wdata_d  = fb_wdata_q;
        line_done_d = 1'b0;
        read_en     = 1'b0;
        start_line  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_line = draw_edge;
            end
            ST_DISCARD: begin
                read_en = !fifo_empty;
                if (read_en) begin
                    discard_d = discard_q - 3'd1;
                    if (discard_q == 3'd1) state_d = ST_PUSH;
                end
                if (!in_draw) state_d = ST_IDLE;
            end
            ST_PUSH: begin
                // A pop in the abort cycle still produces its write next cycle.
                read_en = !fifo_empty;
                if (read_en) begin
                    fb_we_d    = (ly_q < 8'(SCREEN_HEIGHT));
                    fb_addr_d  = (FB_ADDR_W'(ly_q) << 7) + (FB_ADDR_W'(ly_q) << 5)
                               + FB_ADDR_W'(x_pos_q);
                    fb_wdata_d = apply_palette(bgp, fifo_head);
                    x_pos_d    = x_pos_q + 8'd1;
                    if (x_pos_q == 8'(SCREEN_WIDTH - 1)) begin
                        state_d     = ST_DONE;
                        line_done_d = in_draw;
                    end
                end
                if (!in_draw) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (!in_draw) state_d = ST_IDLE;
                // Mode dropped and returned within one cycle: a fresh line.
                start_line = draw_edge;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_line) begin
            ly_d      = ly;
            discard_d = scx_fine;
            x_pos_d   = '0;
            state_d   = (scx_fine != 3'd0) ? ST_DISCARD : ST_PUSH;
        end
    end

    assign fifo_read_en = read_en;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_wdata     = fb_wdata_q;
    assign x_pos        = x_pos_q;
    assign line_done    = line_done_q;

endmodule

// File: doc/ppu_pixel_pusher.md
Name: ppu_pixel_pusher

Overview:
- Consumer end of the background pixel FIFO (Framebuffer_side of FIFO_if); sits between the pixel FIFO and the framebuffer RAM.
- During mode 3 (DRAW), pops one pixel per cycle and discards the first SCX[2:0] pixels of the line.
- Maps each 2-bit colour ID through BGP and writes the shade to the framebuffer at (LY, x).
- Signals line completion after 160 pixels so the PPU timing logic can leave mode 3.

Parameters:
- SCREEN_WIDTH, 160, visible pixels per line.
- SCREEN_HEIGHT, 144, visible lines; LY at or above this produces no writes.
- FB_ADDR_W, 15, framebuffer address width (160*144 = 23040 entries).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  ppu_mode_t  current PPU mode.
- ly  in  8  current line (LY register).
- scx_fine  in  3  SCX[2:0], sampled at line start.
- bgp  in  8  BG palette register, sampled per pixel.
- fifo_read_en  out  1  pop strobe to the pixel FIFO.
- fifo_head  in  gb_color_t  read_data[0], the oldest FIFO pixel; valid whenever fifo_empty = 0.
- fifo_empty  in  1  FIFO has no pixels.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  FB_ADDR_W  framebuffer write address.
- fb_wdata  out  2  shade after BGP mapping.
- x_pos  out  8  number of pixels written on the current line.
- line_done  out  1  one-cycle pulse when pixel 159 is written.

Behaviour:
- Reset values: state = IDLE; fifo_read_en, fb_we, line_done = 0; fb_addr, fb_wdata, x_pos = 0; discard counter = 0.
- States are IDLE, DISCARD, PUSH and DONE.
- IDLE:
  - Waits for the mode transition from any non-DRAW value to DRAW (edge detected with a registered previous mode).
  - On that edge: latch ly; load discard_cnt with scx_fine; x_pos = 0.
  - Next state is DISCARD if scx_fine != 0, otherwise PUSH.
- DISCARD:
  - fifo_read_en = !fifo_empty (combinational). Each pop decrements discard_cnt; no framebuffer write.
  - When a pop takes discard_cnt from 1 to 0, go to PUSH on the next cycle.
- PUSH:
  - fifo_read_en = !fifo_empty (combinational). On a pop, the following registered outputs take effect the next cycle:
    - fb_we = 1 only if latched ly < SCREEN_HEIGHT.
    - fb_addr = ly*160 + x_pos, computed as (ly<<7) + (ly<<5) + x_pos, truncated to FB_ADDR_W.
    - fb_wdata = bgp[2*id+1 : 2*id], where id = fifo_head.
    - x_pos increments.
  - Latency is one cycle from pop to framebuffer write.
  - fifo_empty stalls the pipeline: no pop, fb_we = 0, x_pos holds.
  - On the pop of pixel 159, go to DONE. That pixel's write cycle also asserts line_done for exactly one cycle.
- DONE:
  - fifo_read_en = 0; remaining FIFO contents are left for the PPU to flush.
  - Return to IDLE when mode != DRAW.
- Abort: mode leaving DRAW while in DISCARD or PUSH sends the state to IDLE the next cycle.
  - No further pops. The write for a pop made in the abort cycle still completes. line_done is not asserted.
- Simultaneous DRAW edge while in DONE (mode toggled within one cycle): treated as a new line start.
- fb_we, line_done and fifo_read_en are never asserted in IDLE.
- Reset mid-line: everything returns to reset values the next cycle; no partial write after reset.

Decomposition:
- The following belong in ppu_types_pkg:
  - gb_color_t
  - ppu_mode_t
  - the FIFO_DEPTH constant
  - SCREEN_WIDTH and SCREEN_HEIGHT constants
  - a pusher_state_t enum
- The following function belongs in ppu_util_pkg: apply_palette(bgp, id) returning a 2-bit shade. It is reused later for OBP0/OBP1.
- No sub-module; the address arithmetic is a small inline expression.

Test Plan:
- LY = 0, SCX = 0, BGP = 0xE4, FIFO always non-empty with ids cycling 0..3 -> 160 writes on consecutive cycles.
  - fb_addr runs 0..159; fb_wdata = id; line_done pulses with the write at addr 159.
- LY = 10, SCX = 5, BGP = 0x1B -> the first 5 pops produce no writes.
  - The first write goes to addr 1600; shade for id 0 = 3 and for id 3 = 0; the final write goes to addr 1759.
- fifo_empty held high for 4 cycles after pixel 20 -> fb_we low for those 4 cycles and x_pos holds at 21.
  - Resumes at addr LY*160+21 with no skipped or duplicated addresses.
- LY = 150 with a full line of pixels -> pops occur but fb_we never asserts; line_done still pulses after 160 pops.
- Mode leaves DRAW after 50 pixels -> at most 51 writes; line_done is not asserted.
  - Re-entering DRAW with LY = 11 starts cleanly at addr 1760.
- reset asserted at x_pos = 80 -> the next cycle shows state IDLE and all outputs zero, with no write on the following cycle.
